pipeline_commit_monitor: RTL and testbench

PIPELINE_COMMIT_MONITOR -- requirements
Module: pipeline_commit_monitor

---
 rtl/pipeline_commit_monitor_if.sv | 23 ++
 rtl/pipeline_commit_monitor.sv | 91 +++++++++
 tb/tb_pipeline_commit_monitor.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_commit_monitor_if.sv
// Bundle of decode-side pipeline inputs and commit-status outputs for the
// pipeline commit monitor; the monitor sits on the slave side.
interface pipeline_commit_monitor_if;
  logic        id_valid;
  logic        id_illegal;
  logic        id_ebreak;
  logic        ex_alu_error;
  logic        stall;
  logic        flush;
  logic        cpu_stop;
  logic [1:0]  cpu_error;
  logic [31:0] retired;

  modport master (
    output id_valid, id_illegal, id_ebreak, ex_alu_error, stall, flush,
    input  cpu_stop, cpu_error, retired
  );

  modport slave (
    input  id_valid, id_illegal, id_ebreak, ex_alu_error, stall, flush,
    output cpu_stop, cpu_error, retired
  );
endinterface

// File: rtl/pipeline_commit_monitor.sv
// Shadows the EX/MEM/WB stages with per-instruction tags and decides at WB
// whether each instruction retires, halts the CPU (EBREAK) or faults it.
module pipeline_commit_monitor (
  input  logic                      clk,
  input  logic                      reset,
  pipeline_commit_monitor_if.slave  bus
);

  typedef enum logic [1:0] {RUN, STOPPED, FAULTED} state_e;

  typedef struct packed {
    logic valid;
    logic ebreak;
    logic dec_err;
    logic alu_err;
  } tag_t;

  localparam tag_t BUBBLE = '0;

  state_e      state_q, state_d;
  tag_t        ex_q, ex_d;
  tag_t        mem_q, mem_d;
  tag_t        wb_q, wb_d;
  logic        cpu_stop_q, cpu_stop_d;
  logic [1:0]  cpu_error_q, cpu_error_d;
  logic [31:0] retired_q, retired_d;

  always_comb begin
    // NOTE: every signal gets a hold default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    cpu_stop_d  = cpu_stop_q;
    cpu_error_d = cpu_error_q;
    retired_d   = retired_q;

    if (state_q == RUN) begin
      // A flush or stall kills the ID slot; flush+stall collapses to one bubble.
      if (bus.stall || bus.flush || !bus.id_valid) begin
        ex_d = BUBBLE;
      end else begin
        ex_d = '{valid: 1'b1, ebreak: bus.id_ebreak, dec_err: bus.id_illegal, alu_err: 1'b0};
      end

      mem_d         = ex_q;
      mem_d.alu_err = bus.ex_alu_error & ex_q.valid & ~ex_q.dec_err;
      wb_d          = mem_q;

      // Commit decision; an error outranks EBREAK on the same instruction.
      if (wb_q.valid) begin
        if (wb_q.dec_err || wb_q.alu_err) begin
          state_d     = FAULTED;
          cpu_error_d = {wb_q.dec_err, wb_q.alu_err};
        end else if (wb_q.ebreak) begin
          state_d    = STOPPED;
          cpu_stop_d = 1'b1;
        end else begin
          retired_d = retired_q + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      ex_q        <= BUBBLE;
      mem_q       <= BUBBLE;
      wb_q        <= BUBBLE;
      cpu_stop_q  <= 1'b0;
      cpu_error_q <= 2'b00;
      retired_q   <= 32'd0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q     <= state_d;
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      cpu_stop_q  <= cpu_stop_d;
      cpu_error_q <= cpu_error_d;
      retired_q   <= retired_d;
    end
  end

  assign bus.cpu_stop  = cpu_stop_q;
  assign bus.cpu_error = cpu_error_q;
  assign bus.retired   = retired_q;

endmodule

// File: tb/tb_pipeline_commit_monitor.sv
// Directed and randomized checks of pipeline_commit_monitor against a
// schedule-based model: an instruction issued at edge n commits at edge n+3.
module tb_pipeline_commit_monitor;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_commit_monitor_if bus ();

  pipeline_commit_monitor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef enum {M_RUN, M_STOPPED, M_FAULTED} mstate_e;

  mstate_e     m_state;
  int unsigned m_edge;
  logic [31:0] m_retired;
  logic        m_stop;
  logic [1:0]  m_err;
  bit          iss_valid [8];
  bit          iss_eb    [8];
  bit          iss_ill   [8];
  bit          iss_alu   [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic ill, input logic eb,
                       input logic alu, input logic st, input logic fl);
    bus.id_valid     = v;
    bus.id_illegal   = ill;
    bus.id_ebreak    = eb;
    bus.ex_alu_error = alu;
    bus.stall        = st;
    bus.flush        = fl;
  endtask

  task automatic model_reset();
    m_state   = M_RUN;
    m_edge    = 0;
    m_retired = 0;
    m_stop    = 0;
    m_err     = 2'b00;
    for (int i = 0; i < 8; i++) begin
      iss_valid[i] = 0; iss_eb[i] = 0; iss_ill[i] = 0; iss_alu[i] = 0;
    end
  endtask

  // Model of one rising edge: record what entered the pipe this edge, attach
  // the ALU verdict to the instruction issued one edge ago, and commit the one
  // issued three edges ago.
  task automatic model_edge();
    int unsigned slot;
    int unsigned j;
    logic [1:0]  err;
    if (m_state != M_RUN) return;
    slot            = m_edge % 8;
    iss_valid[slot] = bus.id_valid & !bus.stall & !bus.flush;
    iss_eb[slot]    = bus.id_ebreak;
    iss_ill[slot]   = bus.id_illegal;
    iss_alu[slot]   = 0;
    if (m_edge >= 1) iss_alu[(m_edge - 1) % 8] = bus.ex_alu_error;
    if (m_edge >= 3) begin
      j = (m_edge - 3) % 8;
      if (iss_valid[j]) begin
        err = {iss_ill[j], iss_alu[j] & !iss_ill[j]};
        if (err != 2'b00) begin
          m_state = M_FAULTED;
          m_err   = err;
        end else if (iss_eb[j]) begin
          m_state = M_STOPPED;
          m_stop  = 1;
        end else begin
          m_retired = m_retired + 32'd1;
        end
      end
    end
    m_edge++;
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, ".stop"},    {31'd0, bus.cpu_stop}, {31'd0, m_stop});
    check({tag, ".err"},     {30'd0, bus.cpu_error}, {30'd0, m_err});
    check({tag, ".retired"}, bus.retired, m_retired);
  endtask

  // Reset is raised between edges; outputs must clear before the next edge.
  task automatic apply_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    check({tag, ".rst_stop"},    {31'd0, bus.cpu_stop}, 32'd0);
    check({tag, ".rst_err"},     {30'd0, bus.cpu_error}, 32'd0);
    check({tag, ".rst_retired"}, bus.retired, 32'd0);
    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int stopped_for;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("por.stop",    {31'd0, bus.cpu_stop}, 32'd0);
    check("por.err",     {30'd0, bus.cpu_error}, 32'd0);
    check("por.retired", bus.retired, 32'd0);
    reset = 1'b0;

    // Five plain instructions, then idle until the fifth has committed.
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      tick("t1.issue");
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) tick("t1.drain");
    check("t1.retired5", bus.retired, 32'd5);
    check("t1.no_stop",  {31'd0, bus.cpu_stop}, 32'd0);

    // Three plain instructions, then EBREAK; later garbage must be ignored.
    apply_reset("t2");
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      tick("t2.issue");
    end
    drive(1, 0, 1, 0, 0, 0);
    tick("t2.ebreak");
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) tick("t2.wait");
    check("t2.stop_early", {31'd0, bus.cpu_stop}, 32'd0);
    tick("t2.commit");
    check("t2.stop",       {31'd0, bus.cpu_stop}, 32'd1);
    check("t2.retired3",   bus.retired, 32'd3);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 1, 0, 0);
      tick("t2.ignored");
    end
    check("t2.hold_err",   {30'd0, bus.cpu_error}, 32'd0);
    check("t2.hold_ret",   bus.retired, 32'd3);

    // Illegal instruction squashed by flush, then a plain one.
    apply_reset("t3");
    drive(1, 1, 0, 0, 0, 1);
    tick("t3.flushed");
    drive(1, 0, 0, 0, 0, 0);
    tick("t3.plain");
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) tick("t3.drain");
    check("t3.err", {30'd0, bus.cpu_error}, 32'd0);
    check("t3.ret", bus.retired, 32'd1);

    // ALU fault during EX, with an EBREAK right behind it.
    apply_reset("t4");
    drive(1, 0, 0, 0, 0, 0);
    tick("t4.issue");
    drive(1, 0, 1, 1, 0, 0);
    tick("t4.ex_alu");
    drive(0, 0, 0, 0, 0, 0);
    tick("t4.mem");
    check("t4.err_early", {30'd0, bus.cpu_error}, 32'd0);
    tick("t4.wb");
    check("t4.err01", {30'd0, bus.cpu_error}, 32'd1);
    check("t4.ret0",  bus.retired, 32'd0);
    repeat (4) tick("t4.after");
    check("t4.no_stop", {31'd0, bus.cpu_stop}, 32'd0);

    // Plain instruction, then illegal+EBREAK held by a 3-cycle stall.
    apply_reset("t5");
    drive(1, 0, 0, 0, 0, 0);
    tick("t5.plain");
    drive(1, 1, 1, 0, 1, 0);
    repeat (3) tick("t5.stall");
    drive(1, 1, 1, 0, 0, 0);
    tick("t5.issue");
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) tick("t5.pipe");
    check("t5.err_early", {30'd0, bus.cpu_error}, 32'd0);
    check("t5.ret1",      bus.retired, 32'd1);
    tick("t5.commit");
    check("t5.err10",  {30'd0, bus.cpu_error}, 32'd2);
    check("t5.nostop", {31'd0, bus.cpu_stop}, 32'd0);
    check("t5.ret",    bus.retired, 32'd1);

    // Retired counter wrap, then reset with valid tags in MEM/WB.
    apply_reset("t6");
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    m_retired = 32'hFFFF_FFFF;
    drive(1, 0, 0, 0, 0, 0);
    tick("t6.issue");
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) tick("t6.pipe");
    check("t6.pre_wrap", bus.retired, 32'hFFFF_FFFF);
    tick("t6.wrap");
    check("t6.wrapped", bus.retired, 32'd0);
    drive(1, 0, 0, 0, 0, 0);
    repeat (4) tick("t6.fill");
    check("t6.ret_before_rst", bus.retired, 32'd1);
    apply_reset("t6.mid");
    repeat (4) tick("t6.post");
    check("t6.discarded", bus.retired, 32'd0);

    // Randomized traffic; recover from halts and faults with a reset.
    apply_reset("rnd0");
    stopped_for = 0;
    for (int c = 0; c < 1500; c++) begin
      drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 49) == 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
      tick("rnd");
      if (m_state != M_RUN) stopped_for++;
      if (stopped_for >= 4 || $urandom_range(0, 199) == 0) begin
        apply_reset("rnd");
        stopped_for = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
